// File: rtl/shift_sequencer.sv
// Command-driven sequencer for an external WIDTH-bit bi-directional serial-in shift register.
// Optional `SHIFT_SEQ_ABORT_EN adds an abort input and an rsp_count output.
module shift_sequencer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_len,
  output logic             sr_en,
  output logic             sr_dir,
  output logic             sr_d,
  input  logic [WIDTH-1:0] sr_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
`ifdef SHIFT_SEQ_ABORT_EN
  input  logic             abort,
  output logic [CNT_W-1:0] rsp_count,
`endif
  output logic [WIDTH-1:0] rsp_data
);

  typedef enum logic [1:0] {StIdle, StShift, StSettle, StResp} state_e;

  state_e             state_q, state_d;
  logic               dir_q, dir_d;
  logic [WIDTH-1:0]   buf_q, buf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sr_en_q, sr_en_d;
  logic               sr_d_q, sr_d_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic [CNT_W-1:0]   eff_len;
  logic [WIDTH-1:0]   aligned;
  logic               stop_shift;
`ifdef SHIFT_SEQ_ABORT_EN
  logic [CNT_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   rsp_count_q, rsp_count_d;
`endif

  // Zero and oversize lengths both mean a full-width load.
  always_comb begin
    eff_len = cmd_len;
    if (cmd_len == '0 || cmd_len > CNT_W'(WIDTH)) begin
      eff_len = CNT_W'(WIDTH);
    end
    aligned = cmd_dir ? cmd_data : (cmd_data << (CNT_W'(WIDTH) - eff_len));
  end

`ifdef SHIFT_SEQ_ABORT_EN
  assign stop_shift = (cnt_q == CNT_W'(1)) || abort;
`else
  assign stop_shift = (cnt_q == CNT_W'(1));
`endif

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    buf_d       = buf_q;
    cnt_d       = cnt_q;
    sr_en_d     = 1'b0;
    sr_d_d      = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
`ifdef SHIFT_SEQ_ABORT_EN
    len_d       = len_q;
    rsp_count_d = rsp_count_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          state_d = StShift;
          dir_d   = cmd_dir;
          cnt_d   = eff_len;
          sr_en_d = 1'b1;
          // First bit is presented straight from the aligned word; buffer keeps the rest.
          sr_d_d  = cmd_dir ? aligned[0] : aligned[WIDTH-1];
          buf_d   = cmd_dir ? (aligned >> 1) : (aligned << 1);
`ifdef SHIFT_SEQ_ABORT_EN
          len_d   = eff_len;
`endif
        end
      end
      StShift: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (stop_shift) begin
          state_d = StSettle;
        end else begin
          sr_en_d = 1'b1;
          sr_d_d  = dir_q ? buf_q[0] : buf_q[WIDTH-1];
          buf_d   = dir_q ? (buf_q >> 1) : (buf_q << 1);
        end
      end
      StSettle: begin
        state_d     = StResp;
        rsp_valid_d = 1'b1;
        rsp_data_d  = sr_out;
`ifdef SHIFT_SEQ_ABORT_EN
        rsp_count_d = len_q - cnt_q;
`endif
      end
      StResp: begin
        if (rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      dir_q       <= 1'b0;
      buf_q       <= '0;
      cnt_q       <= '0;
      sr_en_q     <= 1'b0;
      sr_d_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
`ifdef SHIFT_SEQ_ABORT_EN
      len_q       <= '0;
      rsp_count_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      sr_en_q     <= sr_en_d;
      sr_d_q      <= sr_d_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
`ifdef SHIFT_SEQ_ABORT_EN
      len_q       <= len_d;
      rsp_count_q <= rsp_count_d;
`endif
    end
  end

  assign cmd_ready = (state_q == StIdle) && !rst;
  assign sr_en     = sr_en_q;
  assign sr_dir    = dir_q;
  assign sr_d      = sr_d_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
`ifdef SHIFT_SEQ_ABORT_EN
  assign rsp_count = rsp_count_q;
`endif

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer with a behavioural model of the external shift register.
// Exercises the abort path only when SHIFT_SEQ_ABORT_EN is defined.
module tb_shift_sequencer;

  localparam int W = 16;
  localparam int C = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid, cmd_ready, cmd_dir;
  logic [W-1:0] cmd_data;
  logic [C-1:0] cmd_len;
  logic         sr_en, sr_dir, sr_d;
  logic [W-1:0] sr_reg;
  logic         sr_clr;
  logic         rsp_valid, rsp_ready;
  logic [W-1:0] rsp_data;
`ifdef SHIFT_SEQ_ABORT_EN
  logic         abort;
  logic [C-1:0] rsp_count;
`endif

  shift_sequencer #(.WIDTH(W), .CNT_W(C)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dir   (cmd_dir),
    .cmd_data  (cmd_data),
    .cmd_len   (cmd_len),
    .sr_en     (sr_en),
    .sr_dir    (sr_dir),
    .sr_d      (sr_d),
    .sr_out    (sr_reg),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
`ifdef SHIFT_SEQ_ABORT_EN
    .abort     (abort),
    .rsp_count (rsp_count),
`endif
    .rsp_data  (rsp_data)
  );

  always #5 clk = ~clk;

  // External shift register; never reset by the sequencer.
  always @(posedge clk) begin
    if (sr_clr) sr_reg <= '0;
    else if (sr_en) sr_reg <= sr_dir ? {sr_d, sr_reg[W-1:1]} : {sr_reg[W-2:0], sr_d};
  end

  int           n_vec = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           c0 = 0;
  int           en_cnt = 0;
  logic         exp_dir = 1'b0;
  logic         bit_q[$];
  logic [W-1:0] rsp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_bit(input logic dir, input logic [W-1:0] data, input int l,
                                   input int k);
    logic b;
    if (dir) b = data[k];
    else b = data[l-1-k];
    return b;
  endfunction

  function automatic logic [W-1:0] model(input logic [W-1:0] r, input logic dir,
                                         input logic [W-1:0] data, input int l, input int n);
    logic [W-1:0] v = r;
    for (int k = 0; k < n; k++) begin
      if (dir) v = {get_bit(dir, data, l, k), v[W-1:1]};
      else v = {v[W-2:0], get_bit(dir, data, l, k)};
    end
    return v;
  endfunction

  // Monitor: serial stream and response handshakes against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (sr_en) begin
        en_cnt++;
        if (bit_q.size() == 0) check_eq("sr_en_extra", sr_en, 0);
        else begin
          check_eq("sr_d", sr_d, bit_q.pop_front());
          check_eq("sr_dir", sr_dir, exp_dir);
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (rsp_q.size() == 0) check_eq("rsp_unexpected", rsp_valid, 0);
        else check_eq("rsp_data_sb", rsp_data, rsp_q.pop_front());
      end
    end
  end

  task automatic clear_reg();
    @(posedge clk); #1 sr_clr = 1'b1;
    @(posedge clk); #1 sr_clr = 1'b0;
  endtask

  // Issue one command; n is the number of shifts expected to be issued.
  task automatic send(input logic dir, input logic [W-1:0] data, input logic [C-1:0] len,
                      input int n);
    int l;
    l = (len == 0 || int'(len) > W) ? W : int'(len);
    @(posedge clk); #1;
    for (int i = 0; i < 100 && !cmd_ready; i++) begin
      @(posedge clk); #1;
    end
    check_eq("cmd_ready_wait", cmd_ready, 1);
    for (int k = 0; k < n; k++) bit_q.push_back(get_bit(dir, data, l, k));
    rsp_q.push_back(model(sr_reg, dir, data, l, n));
    exp_dir   = dir;
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    cmd_data  = data;
    cmd_len   = len;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    c0        = cyc;
    en_cnt    = 0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = cyc - c0 + 1;
        break;
      end
    end
    if (lat < 0) check_eq("rsp_timeout", rsp_valid, 1);
  endtask

  task automatic run_cmd(input logic dir, input logic [W-1:0] data, input logic [C-1:0] len,
                         input int l, input logic [W-1:0] exp_data);
    int lat;
    send(dir, data, len, l);
    wait_rsp(lat);
    check_eq("rsp_latency", lat, l + 2);
    check_eq("rsp_data", rsp_data, exp_data);
    check_eq("shift_count", en_cnt, l);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_data = '0; cmd_len = '0;
    rsp_ready = 1'b1; sr_clr = 1'b0;
`ifdef SHIFT_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    #12;
    check_eq("rst_cmd_ready", cmd_ready, 0);
    check_eq("rst_sr_en", sr_en, 0);
    check_eq("rst_sr_d", sr_d, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_data", rsp_data, 0);
    #4 rst = 1'b0;
    #1 check_eq("idle_cmd_ready", cmd_ready, 1);

    clear_reg();
    run_cmd(1'b0, 16'hA5C3, 5'd0, 16, 16'hA5C3);
    clear_reg();
    run_cmd(1'b1, 16'h8001, 5'd16, 16, 16'h8001);
    clear_reg();
    run_cmd(1'b0, 16'h000B, 5'd4, 4, 16'h000B);
    run_cmd(1'b1, 16'h0003, 5'd2, 2, 16'hC002);
    clear_reg();
    run_cmd(1'b1, 16'h5A3C, 5'd20, 16, 16'h5A3C);
    run_cmd(1'b0, 16'hF00D, 5'd31, 16, 16'hF00D);

    // Response backpressure with a competing command.
    clear_reg();
    rsp_ready = 1'b0;
    send(1'b0, 16'h1234, 5'd8, 8);
    wait_rsp(lat);
    check_eq("bp_latency", lat, 10);
    cmd_valid = 1'b1; cmd_data = 16'hFFFF; cmd_len = 5'd3;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("bp_rsp_valid", rsp_valid, 1);
      check_eq("bp_rsp_data", rsp_data, 16'h0034);
      check_eq("bp_cmd_ready", cmd_ready, 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1; cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("bp_cmd_ready_after", cmd_ready, 1);
    check_eq("bp_rsp_cleared", rsp_valid, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("bp_no_accept", sr_en, 0);
    end

    // Reset in the middle of a shift burst.
    clear_reg();
    send(1'b0, 16'hBEEF, 5'd0, 16);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("mid_rst_sr_en", sr_en, 0);
    check_eq("mid_rst_cmd_ready", cmd_ready, 0);
    bit_q.delete();
    rsp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    #1 check_eq("mid_rst_cmd_ready_after", cmd_ready, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_eq("mid_rst_no_rsp", rsp_valid, 0);
      check_eq("mid_rst_no_shift", sr_en, 0);
    end

`ifdef SHIFT_SEQ_ABORT_EN
    clear_reg();
    send(1'b0, 16'hC3A5, 5'd16, 6);
    repeat (5) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    wait_rsp(lat);
    check_eq("abort_latency", lat, 8);
    check_eq("abort_count", rsp_count, 6);
    check_eq("abort_shifts", en_cnt, 6);
    check_eq("abort_rsp_data", rsp_data, 16'h0030);
    @(posedge clk); #1;
    run_cmd(1'b1, 16'h00FF, 5'd8, 8, 16'hFF00);
    check_eq("full_count", rsp_count, 8);
`endif

    repeat (3) @(posedge clk);
    check_eq("sb_rsp_drained", rsp_q.size(), 0);
    check_eq("sb_bits_drained", bit_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Command-driven controller that sequences an external WIDTH-bit bi-directional serial-in shift register by driving its enable, direction and serial data.
- Takes a parallel word plus shift count and direction over a valid/ready command port, then serialises it into the register one bit per clock.
- After the last shift, samples the register's parallel output and returns it on a valid/ready response port.
- Sits between a host/bus-side requester and the shift-register datapath.

Parameters:
WIDTH, 16, width of the controlled shift register and of cmd_data/rsp_data
CNT_W, 5, width of cmd_len and the shift counter; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  system clock, all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_dir  input  1  0 = shift-left mode (register does out <= {out[W-2:0], d}); 1 = shift-right mode (out <= {d, out[W-1:1]})
cmd_data  input  WIDTH  word to serialise
cmd_len  input  CNT_W  number of shifts; 0 means WIDTH; values > WIDTH are clamped to WIDTH
sr_en  output  1  shift enable to the register
sr_dir  output  1  direction to the register
sr_d  output  1  serial data to the register
sr_out  input  WIDTH  parallel output of the register
rsp_valid  output  1  response present
rsp_ready  input  1  requester accepts response
rsp_data  output  WIDTH  sr_out sampled after the final shift

Behaviour:
- Reset (async, any state): state=IDLE; cmd_ready=0 while rst is high, then 1 in IDLE; sr_en=0; sr_dir=0; sr_d=0; rsp_valid=0; rsp_data=0; counter=0; internal buffer=0.
- FSM states: IDLE, SHIFT, SETTLE, RESP.
- IDLE:
  - cmd_ready=1, sr_en=0.
  - On cmd_valid && cmd_ready: latch cmd_dir, the effective length L (per cmd_len rules), and an aligned buffer, then go to SHIFT.
  - Buffer alignment: dir=0 → buffer = cmd_data << (WIDTH-L), so bit L-1 sits at the MSB. dir=1 → buffer = cmd_data.
- SHIFT:
  - cmd_ready=0, sr_en=1, sr_dir=latched dir.
  - sr_d = buffer[WIDTH-1] when dir=0 (MSB-first); sr_d = buffer[0] when dir=1 (LSB-first).
  - Each edge: buffer shifts one place toward the consumed end, counter decrements.
  - Exactly L cycles with sr_en=1, then go to SETTLE.
  - sr_en, sr_dir and sr_d are registered outputs: no combinational path from cmd_* to sr_*.
- SETTLE:
  - One cycle with sr_en=0.
  - At the end of this cycle rsp_data <= sr_out, then go to RESP.
- RESP:
  - rsp_valid=1; rsp_data stays stable until rsp_ready.
  - On rsp_valid && rsp_ready: go to IDLE and clear rsp_valid.
- Latency: command handshake at edge T0 → sr_en high in cycles T0+1 .. T0+L → rsp_valid high from T0+L+2. Minimum spacing between accepted commands is L+3 cycles.
- Backpressure:
  - rsp_ready held low: stay in RESP indefinitely; cmd_ready stays 0.
  - cmd_valid while busy: ignored, not latched.
- Boundary cases:
  - cmd_len=0 and cmd_len=WIDTH are identical.
  - cmd_len > WIDTH behaves as WIDTH.
  - rsp_ready already high when RESP is entered: response completes in one cycle.
- Reset mid-SHIFT: sr_en drops immediately (async), the transaction is discarded, and no response is produced.
- This block never resets or loads the shift register; the register's contents before the command persist in the unshifted bits.

Optional Feature:
- Macro: SHIFT_SEQ_ABORT_EN.
- Defined:
  - Adds input abort (1 bit) and output rsp_count (CNT_W bits).
  - abort high at an edge while in SHIFT: sr_en=0 from the next cycle, go to SETTLE, then RESP as normal.
  - rsp_count = number of shifts actually issued.
  - abort in any other state is ignored.
  - Without abort, rsp_count = L.
  - rsp_count resets to 0.
- Undefined: abort and rsp_count ports are absent, and the FSM has no abort path.

Test Plan:
- Register cleared, cmd dir=0, data=16'hA5C3, len=0 → sr_en high exactly 16 cycles, sr_d sequence 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1; rsp_valid at T0+18; rsp_data=16'hA5C3.
- Register cleared, cmd dir=1, data=16'h8001, len=16 → sr_d sequence 1 then 0x14 then 1; rsp_data=16'h8001.
- Register cleared, cmd dir=0, data=16'h000B, len=4 → 4 shifts (1,0,1,1); rsp_data=16'h000B. Then dir=1, data=16'h0003, len=2 → rsp_data=16'hC002.
- rsp_ready held low for 10 cycles → rsp_valid and rsp_data stable, cmd_ready=0, a new cmd_valid is not accepted; after rsp_ready=1, cmd_ready=1 on the next cycle.
- rst pulsed high mid-SHIFT after 5 shifts → sr_en=0 within the same cycle, rsp_valid never asserts, cmd_ready=1 after rst drops.
- With SHIFT_SEQ_ABORT_EN: len=16, abort after 6 shifts → rsp_count=6, rsp_valid asserts 2 cycles after the abort edge.
